// File: rtl/obstacle_pkg.sv
// Shared types and widths for the scrolling obstacle field.
package obstacle_pkg;

  // Screen x coordinate width; comparisons use one extra bit so x+width cannot wrap.
  localparam int X_W   = 13;
  localparam int CMP_W = X_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CHECK,
    SPAWN_WAIT
  } sched_state_t;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [15:0]    freq;
    logic [7:0]     note;
  } obstacle_t;

endpackage

// File: rtl/slot_finder.sv
// Lowest-index free-slot priority encoder for the obstacle pool.
module slot_finder #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_SLOTS-1:0] valid_in,
  output logic                 found_out,
  output logic [IDX_W-1:0]     index_out
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    found_out = 1'b0;
    index_out = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_in[i]) begin
        found_out = 1'b1;
        index_out = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-synchronous obstacle pool: scrolls active slots once per frame,
// spawns new obstacles through a req/ack handshake and scores passes.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SCREEN_WIDTH = 1280,
  parameter int BLOCK_WIDTH  = 32,
  parameter int SPEED        = 2,
  parameter int SPACING      = 320,
  parameter int PLAYER_X     = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_frame,
  input  logic                           game_active,
  input  logic                           spawn_ack,
  input  logic [15:0]                    spawn_freq_in,
  input  logic [7:0]                     spawn_note_in,
  output logic                           spawn_req,
  output logic [NUM_SLOTS-1:0]           obs_valid_out,
  output logic [NUM_SLOTS-1:0][X_W-1:0]  obs_x_out,
  output logic [NUM_SLOTS-1:0][15:0]     obs_freq_out,
  output logic [NUM_SLOTS-1:0][7:0]      obs_note_out,
  output logic [15:0]                    score_out,
  output logic                           pass_pulse,
  output logic                           frame_overrun,
  output logic                           busy_out
);

  localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DIST_W = $clog2(SPACING + SPEED + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CMP_W-1:0]  SPEED_C   = CMP_W'(SPEED);
  localparam logic [CMP_W-1:0]  BLOCK_C   = CMP_W'(BLOCK_WIDTH);
  localparam logic [CMP_W-1:0]  PLAYER_C  = CMP_W'(PLAYER_X);
  localparam logic [DIST_W-1:0] SPACING_C = DIST_W'(SPACING);
  localparam logic [DIST_W-1:0] STEP_C    = DIST_W'(SPEED);
  localparam logic [X_W-1:0]    SPAWN_X   = X_W'(SCREEN_WIDTH);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  obstacle_t         slots_q [NUM_SLOTS];
  obstacle_t         slots_d [NUM_SLOTS];
  logic [15:0]       score_q, score_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              spawn_req_q, spawn_req_d;
  logic              pass_q, pass_d;
  logic              overrun_q, overrun_d;

  logic [NUM_SLOTS-1:0] valid_vec;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  obstacle_t            cur_slot, scrolled_slot;
  logic                 scroll_pass;
  logic [CMP_W-1:0]     old_x_c, new_x_c;
  logic [DIST_W-1:0]    dist_sum, dist_sat;

  // Flatten slot valids for the free-slot encoder.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) valid_vec[i] = slots_q[i].valid;
  end

  slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_slot_finder (
    .valid_in  (valid_vec),
    .found_out (free_found),
    .index_out (free_idx)
  );

  // Scroll datapath for the slot currently addressed by idx_q.
  always_comb begin
    cur_slot      = slots_q[idx_q];
    old_x_c       = {1'b0, cur_slot.x};
    new_x_c       = old_x_c - SPEED_C;
    scrolled_slot = cur_slot;
    scroll_pass   = 1'b0;
    if (cur_slot.valid) begin
      if (old_x_c < SPEED_C) begin
        // Leaving the screen: retire in place, x is left as it was.
        scrolled_slot.valid = 1'b0;
      end else begin
        scrolled_slot.x = new_x_c[X_W-1:0];
        scroll_pass     = (old_x_c + BLOCK_C >= PLAYER_C) &&
                          (new_x_c + BLOCK_C <  PLAYER_C);
      end
    end
  end

  // Spawn distance advances by one scroll step and saturates at SPACING.
  always_comb begin
    dist_sum = dist_q + STEP_C;
    dist_sat = (dist_sum >= SPACING_C) ? SPACING_C : dist_sum;
  end

  // Next-state logic for the scheduler FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slots_d     = slots_q;
    score_d     = score_q;
    dist_d      = dist_q;
    spawn_req_d = spawn_req_q;
    pass_d      = 1'b0;
    overrun_d   = new_frame && (state_q != IDLE);

    if (state_q != IDLE && !game_active) begin
      // Game paused mid-frame: abandon the frame, keep what was already scrolled.
      state_d     = IDLE;
      idx_d       = '0;
      spawn_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_frame && game_active) begin
            state_d = SCROLL;
            idx_d   = '0;
          end
        end
        SCROLL: begin
          slots_d[idx_q] = scrolled_slot;
          if (scroll_pass) begin
            pass_d  = 1'b1;
            score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          end
          if (idx_q == LAST_IDX) state_d = CHECK;
          else                   idx_d   = idx_q + 1'b1;
        end
        CHECK: begin
          dist_d  = dist_sat;
          state_d = (dist_sat >= SPACING_C && free_found) ? SPAWN_WAIT : IDLE;
        end
        SPAWN_WAIT: begin
          // First cycle raises the request; ack is only honoured once it is visible.
          if (!spawn_req_q) begin
            spawn_req_d = 1'b1;
          end else if (spawn_ack) begin
            if (free_found) begin
              slots_d[free_idx] = '{valid: 1'b1, x: SPAWN_X,
                                    freq: spawn_freq_in, note: spawn_note_in};
            end
            dist_d      = '0;
            spawn_req_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Single state register for the FSM, pool and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      score_q     <= '0;
      dist_q      <= SPACING_C;
      spawn_req_q <= 1'b0;
      pass_q      <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the slot pool is reset because sprites read valid/x directly; stale valids would draw phantom blocks.
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      idx_q       <= idx_d;
      score_q     <= score_d;
      dist_q      <= dist_d;
      spawn_req_q <= spawn_req_d;
      pass_q      <= pass_d;
      overrun_q   <= overrun_d;
      slots_q     <= slots_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      obs_valid_out[i] = slots_q[i].valid;
      obs_x_out[i]     = slots_q[i].x;
      obs_freq_out[i]  = slots_q[i].freq;
      obs_note_out[i]  = slots_q[i].note;
    end
  end

  assign spawn_req     = spawn_req_q;
  assign score_out     = score_q;
  assign pass_pulse    = pass_q;
  assign frame_overrun = overrun_q;
  assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a frame-level model predicts
// spawns and passes, expected records are queued and popped as the DUT acts.
module tb_obstacle_scheduler;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  new_frame;
  logic                  game_active;
  logic                  spawn_ack;
  logic [15:0]           spawn_freq_in;
  logic [7:0]            spawn_note_in;
  logic                  spawn_req;
  logic [N-1:0]          obs_valid_out;
  logic [N-1:0][12:0]    obs_x_out;
  logic [N-1:0][15:0]    obs_freq_out;
  logic [N-1:0][7:0]     obs_note_out;
  logic [15:0]           score_out;
  logic                  pass_pulse;
  logic                  frame_overrun;
  logic                  busy_out;

  obstacle_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .new_frame     (new_frame),
    .game_active   (game_active),
    .spawn_ack     (spawn_ack),
    .spawn_freq_in (spawn_freq_in),
    .spawn_note_in (spawn_note_in),
    .spawn_req     (spawn_req),
    .obs_valid_out (obs_valid_out),
    .obs_x_out     (obs_x_out),
    .obs_freq_out  (obs_freq_out),
    .obs_note_out  (obs_note_out),
    .score_out     (score_out),
    .pass_pulse    (pass_pulse),
    .frame_overrun (frame_overrun),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model of the pool, advanced one whole frame at a time.
  bit          m_valid [N];
  int          m_x     [N];
  logic [15:0] m_freq  [N];
  logic [7:0]  m_note  [N];
  int          m_score;
  int          m_dist;
  int          spawn_count;

  typedef struct {
    int          idx;
    logic [15:0] freq;
    logic [7:0]  note;
  } spawn_exp_t;

  spawn_exp_t spawn_q[$];
  int         pass_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_x[i] = 0; m_freq[i] = '0; m_note[i] = '0;
    end
    m_score = 0;
    m_dist  = 320;
    spawn_q.delete();
    pass_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; new_frame = 1'b0; spawn_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_ack(input int idx);
    spawn_exp_t se;
    spawn_freq_in = 16'h0400 + 16'(spawn_count) * 16'h0111;
    spawn_note_in = 8'(60 + spawn_count);
    spawn_ack     = 1'b1;
    se.idx  = idx;
    se.freq = spawn_freq_in;
    se.note = spawn_note_in;
    spawn_q.push_back(se);
    if (idx >= 0) begin
      m_valid[idx] = 1'b1; m_x[idx] = 1280;
      m_freq[idx] = se.freq; m_note[idx] = se.note;
    end
    m_dist = 0;
    spawn_count++;
  endtask

  // Called right after the ack edge: pop the expected spawn and compare.
  task automatic check_spawn_pop();
    spawn_exp_t se;
    spawn_ack = 1'b0;
    se = spawn_q.pop_front();
    checks++;
    if (spawn_req !== 1'b0) begin
      failures++; $display("FAIL spawn_req_drop: got %b want 0", spawn_req);
    end
    if (se.idx >= 0) begin
      checks++;
      if (obs_valid_out[se.idx] !== 1'b1 || obs_x_out[se.idx] !== 13'd1280 ||
          obs_freq_out[se.idx] !== se.freq || obs_note_out[se.idx] !== se.note) begin
        failures++;
        $display("FAIL spawn_slot%0d: got v=%b x=%0d f=%h n=%0d want v=1 x=1280 f=%h n=%0d",
                 se.idx, obs_valid_out[se.idx], obs_x_out[se.idx], obs_freq_out[se.idx],
                 obs_note_out[se.idx], se.freq, se.note);
      end
    end
  endtask

  task automatic compare_pool(input int frame_no);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_valid_out[i] !== m_valid[i] || obs_x_out[i] !== 13'(m_x[i]) ||
          obs_freq_out[i] !== m_freq[i] || obs_note_out[i] !== m_note[i]) begin
        failures++;
        $display("FAIL pool f%0d slot%0d: got v=%b x=%0d f=%h n=%0d want v=%b x=%0d f=%h n=%0d",
                 frame_no, i, obs_valid_out[i], obs_x_out[i], obs_freq_out[i], obs_note_out[i],
                 m_valid[i], m_x[i], m_freq[i], m_note[i]);
      end
    end
    checks++;
    if (score_out !== 16'(m_score)) begin
      failures++; $display("FAIL score f%0d: got %0d want %0d", frame_no, score_out, m_score);
    end
  endtask

  // One complete frame with zero-wait ack; checks timing, passes and pool.
  task automatic run_frame(input int frame_no, output bit got_req, output int got_pass);
    int  exp_spawn;
    int  cyc;
    int  req_cyc;
    bit  done;
    bit  ack_pending;
    bit  overrun_seen;
    int  nx;
    int  e;

    // Predict: scroll, retire, pass, then spawn decision on the updated distance.
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        if (m_x[i] < 2) m_valid[i] = 1'b0;
        else begin
          nx = m_x[i] - 2;
          if (m_x[i] + 32 >= 200 && nx + 32 < 200) begin
            pass_q.push_back(i);
            if (m_score < 65535) m_score++;
          end
          m_x[i] = nx;
        end
      end
    end
    m_dist = (m_dist + 2 > 320) ? 320 : m_dist + 2;
    exp_spawn = -1;
    if (m_dist >= 320)
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) exp_spawn = i;

    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    cyc = 0; req_cyc = -1; done = 1'b0; ack_pending = 1'b0;
    overrun_seen = 1'b0; got_pass = 0;
    while (!done && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_overrun) overrun_seen = 1'b1;
      if (ack_pending) begin
        ack_pending = 1'b0;
        check_spawn_pop();
      end
      if (pass_pulse) begin
        got_pass++;
        checks++;
        if (pass_q.size() == 0) begin
          failures++; $display("FAIL pass_unexpected f%0d: got pulse at cycle %0d want none", frame_no, cyc);
        end else begin
          e = pass_q.pop_front();
          if (cyc != e + 1) begin
            failures++; $display("FAIL pass_timing f%0d: got cycle %0d want %0d", frame_no, cyc, e + 1);
          end
        end
      end
      if (spawn_req && req_cyc < 0) begin
        req_cyc = cyc;
        checks++;
        if (cyc != 6) begin
          failures++; $display("FAIL req_timing f%0d: got cycle %0d want 6", frame_no, cyc);
        end
        drive_ack(exp_spawn);
        ack_pending = 1'b1;
      end else if (!busy_out) begin
        done = 1'b1;
      end
    end
    spawn_ack = 1'b0;
    got_req = (req_cyc >= 0);

    checks++;
    if (!done) begin
      failures++; $display("FAIL frame_timeout f%0d: got busy after %0d cycles want idle", frame_no, cyc);
    end
    checks++;
    if (got_req != (exp_spawn >= 0)) begin
      failures++; $display("FAIL req_presence f%0d: got %b want %b", frame_no, got_req, exp_spawn >= 0);
    end
    checks++;
    if (pass_q.size() != 0) begin
      failures++; $display("FAIL pass_missing f%0d: got %0d pending want 0", frame_no, pass_q.size());
      pass_q.delete();
    end
    checks++;
    if (overrun_seen) begin
      failures++; $display("FAIL overrun_spurious f%0d: got 1 want 0", frame_no);
    end
    compare_pool(frame_no);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_valid_out !== '0 || obs_x_out !== '0 || obs_freq_out !== '0 || obs_note_out !== '0 ||
        score_out !== 16'd0 || spawn_req !== 1'b0 || pass_pulse !== 1'b0 ||
        frame_overrun !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b score=%0d req=%b pass=%b ovr=%b busy=%b want all zero",
               obs_valid_out, score_out, spawn_req, pass_pulse, frame_overrun, busy_out);
    end
  endtask

  task automatic test_idle_inactive();
    game_active = 1'b0;
    new_frame   = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || frame_overrun !== 1'b0) begin
      failures++; $display("FAIL inactive_frame: got busy=%b ovr=%b want 0 0", busy_out, frame_overrun);
    end
    game_active = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_spawn();
    bit got_req; int got_pass;
    spawn_count = 0;
    run_frame(0, got_req, got_pass);
    checks++;
    if (obs_freq_out[0] !== 16'h0400 || obs_note_out[0] !== 8'd60) begin
      failures++; $display("FAIL first_spawn_data: got f=%h n=%0d want f=0400 n=60",
                           obs_freq_out[0], obs_note_out[0]);
    end
  endtask

  // Frames 1..645: spacing, pass/score, retire and pool-full reuse.
  task automatic test_long_play();
    bit got_req; int got_pass;
    for (int f = 1; f <= 645; f++) begin
      run_frame(f, got_req, got_pass);
      if (f == 160) begin
        checks++;
        if (!got_req || obs_x_out[0] !== 13'd960 || obs_valid_out[1] !== 1'b1) begin
          failures++; $display("FAIL spacing_160: got req=%b x0=%0d v1=%b want 1 960 1",
                               got_req, obs_x_out[0], obs_valid_out[1]);
        end
      end
      if (f == 556) begin
        // Right edge 202 -> 200: not yet below the player column.
        checks++;
        if (got_pass != 0 || obs_x_out[0] !== 13'd168 || score_out !== 16'd0) begin
          failures++; $display("FAIL prepass_556: got pulses=%0d x=%0d score=%0d want 0 168 0",
                               got_pass, obs_x_out[0], score_out);
        end
      end
      if (f == 557) begin
        // Right edge 200 -> 198 crosses below PLAYER_X.
        checks++;
        if (got_pass != 1 || obs_x_out[0] !== 13'd166 || score_out !== 16'd1) begin
          failures++; $display("FAIL pass_557: got pulses=%0d x=%0d score=%0d want 1 166 1",
                               got_pass, obs_x_out[0], score_out);
        end
      end
      if (f == 640) begin
        checks++;
        if (got_req || obs_valid_out !== 4'b1111 || obs_x_out[0] !== 13'd0) begin
          failures++; $display("FAIL pool_full_640: got req=%b v=%b x0=%0d want 0 1111 0",
                               got_req, obs_valid_out, obs_x_out[0]);
        end
      end
      if (f == 641) begin
        checks++;
        if (!got_req || got_pass != 0 || obs_valid_out[0] !== 1'b1 || obs_x_out[0] !== 13'd1280) begin
          failures++; $display("FAIL reuse_641: got req=%b pulses=%0d v0=%b x0=%0d want 1 0 1 1280",
                               got_req, got_pass, obs_valid_out[0], obs_x_out[0]);
        end
      end
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (spawn_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (spawn_req !== 1'b1) begin
      failures++; $display("FAIL %s_req_timeout: got %b want 1", tag, spawn_req);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    new_frame = 1'b1; @(posedge clk); #1; new_frame = 1'b0;
    wait_req("overrun");
    new_frame = 1'b1; @(posedge clk); #1; new_frame = 1'b0;
    checks++;
    if (frame_overrun !== 1'b1 || busy_out !== 1'b1 || spawn_req !== 1'b1) begin
      failures++; $display("FAIL overrun_pulse: got ovr=%b busy=%b req=%b want 1 1 1",
                           frame_overrun, busy_out, spawn_req);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_overrun !== 1'b0 || spawn_req !== 1'b1 || obs_valid_out !== '0) begin
      failures++; $display("FAIL overrun_clear: got ovr=%b req=%b v=%b want 0 1 0000",
                           frame_overrun, spawn_req, obs_valid_out);
    end
    drive_ack(0);
    @(posedge clk); #1;
    check_spawn_pop();
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    do_reset();
    new_frame = 1'b1; @(posedge clk); #1; new_frame = 1'b0;
    wait_req("abort");
    game_active = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (spawn_req !== 1'b0 || busy_out !== 1'b0 || obs_valid_out !== '0) begin
      failures++; $display("FAIL abort: got req=%b busy=%b v=%b want 0 0 0000",
                           spawn_req, busy_out, obs_valid_out);
    end
    game_active = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scroll();
    bit got_req; int got_pass;
    do_reset();
    run_frame(0, got_req, got_pass);
    new_frame = 1'b1; @(posedge clk); #1; new_frame = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_x_out[0] !== 13'd1278 || busy_out !== 1'b1) begin
      failures++; $display("FAIL midscroll_pre: got x0=%0d busy=%b want 1278 1", obs_x_out[0], busy_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_valid_out !== '0 || obs_x_out !== '0 || obs_freq_out !== '0 || obs_note_out !== '0 ||
        score_out !== 16'd0 || spawn_req !== 1'b0 || pass_pulse !== 1'b0 ||
        frame_overrun !== 1'b0 || busy_out !== 1'b0) begin
      failures++; $display("FAIL midscroll_reset: got v=%b x0=%0d busy=%b req=%b want all zero",
                           obs_valid_out, obs_x_out[0], busy_out, spawn_req);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; game_active = 1'b1; spawn_ack = 1'b0;
    spawn_freq_in = '0; spawn_note_in = '0; spawn_count = 0;
    model_reset();
    test_reset();
    test_idle_inactive();
    test_first_spawn();
    test_long_play();
    test_overrun();
    test_abort();
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
